// File: rtl/note_sequencer_ctrl.sv
// Note RAM playback controller: walks the 64-entry note RAM, decodes NOTE/REST/END
// words, offers notes over valid/ready and holds each entry for its beat count.
module note_sequencer_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              play,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic              tick,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              note_valid,
    input  logic              note_ready,
    output logic [23:0]       note_data,
    output logic              gate,
    output logic              playing,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0]        OP_NOTE   = 2'b00;
    localparam logic [1:0]        OP_END    = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   rd_addr_r, rd_addr_s;
    logic [23:0]         note_data_r, note_data_s;
    logic [5:0]          beat_cnt_r, beat_cnt_s;
    logic                gate_r, gate_s;
    logic                rd_en_r, note_valid_r, playing_r, done_r;

    // A zero duration still occupies one beat.
    function automatic logic [5:0] beats_of(input logic [5:0] dur);
        beats_of = (dur == 6'd0) ? 6'd1 : dur;
    endfunction

    // Next-state and next-datapath decode for the playback FSM
    always_comb begin
        state_s     = state_r;
        rd_addr_s   = rd_addr_r;
        note_data_s = note_data_r;
        gate_s      = gate_r;
        beat_cnt_s  = beat_cnt_r;
        if (stop) begin
            state_s    = ST_IDLE;
            rd_addr_s  = ADDR_ZERO;
            gate_s     = 1'b0;
            beat_cnt_s = 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rd_addr_s = ADDR_ZERO;
                    if (play) state_s = ST_FETCH;
                    else      state_s = ST_IDLE;
                end
                ST_FETCH: begin
                    state_s = ST_WAIT_RD;
                end
                ST_WAIT_RD: begin
                    // Counter is preloaded here; it only counts once HOLD is reached.
                    beat_cnt_s = beats_of(rd_data[29:24]);
                    case (rd_data[31:30])
                        OP_NOTE: begin
                            note_data_s = rd_data[23:0];
                            state_s     = ST_ISSUE;
                        end
                        OP_END: begin
                            if (loop_en) begin
                                rd_addr_s = ADDR_ZERO;
                                state_s   = ST_FETCH;
                            end else begin
                                state_s = ST_DONE;
                            end
                        end
                        default: begin
                            gate_s  = 1'b0;
                            state_s = ST_HOLD;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    if (note_ready) begin
                        gate_s  = 1'b1;
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end
                ST_HOLD: begin
                    if (tick && !pause) begin
                        if (beat_cnt_r <= 6'd1) begin
                            beat_cnt_s = 6'd0;
                            gate_s     = 1'b0;
                            if (rd_addr_r == ADDR_LAST) begin
                                if (loop_en) begin
                                    rd_addr_s = ADDR_ZERO;
                                    state_s   = ST_FETCH;
                                end else begin
                                    state_s = ST_DONE;
                                end
                            end else begin
                                rd_addr_s = rd_addr_r + ADDR_ONE;
                                state_s   = ST_FETCH;
                            end
                        end else begin
                            beat_cnt_s = beat_cnt_r - 6'd1;
                        end
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_DONE: begin
                    if (play) begin
                        rd_addr_s = ADDR_ZERO;
                        state_s   = ST_FETCH;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s   = ST_IDLE;
                    rd_addr_s = ADDR_ZERO;
                    gate_s    = 1'b0;
                end
            endcase
        end
    end

    // State register and outputs registered from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            rd_addr_r    <= ADDR_ZERO;
            note_data_r  <= 24'd0;
            beat_cnt_r   <= 6'd0;
            gate_r       <= 1'b0;
            rd_en_r      <= 1'b0;
            note_valid_r <= 1'b0;
            playing_r    <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            rd_addr_r    <= rd_addr_s;
            note_data_r  <= note_data_s;
            beat_cnt_r   <= beat_cnt_s;
            gate_r       <= gate_s;
            rd_en_r      <= (state_s == ST_FETCH);
            note_valid_r <= (state_s == ST_ISSUE);
            playing_r    <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            done_r       <= (state_s == ST_DONE) && (state_r != ST_DONE);
        end
    end

    assign rd_addr    = rd_addr_r;
    assign rd_en      = rd_en_r;
    assign note_valid = note_valid_r;
    assign note_data  = note_data_r;
    assign gate       = gate_r;
    assign playing    = playing_r;
    assign done       = done_r;

endmodule

// File: tb/tb_note_sequencer_ctrl.sv
// Self-checking bench for note_sequencer_ctrl: directed scenarios plus randomized
// playback checked against a RAM-walking reference of expected notes and beats.
module tb_note_sequencer_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        play = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0, tick = 1'b0;
    logic [5:0]  rd_addr;
    logic        rd_en;
    logic [31:0] rd_data = 32'd0;
    logic        note_valid;
    logic        note_ready = 1'b0;
    logic [23:0] note_data;
    logic        gate, playing, done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:63];

    note_sequencer_ctrl dut (
        .clk(clk), .resetn(resetn), .play(play), .stop(stop), .pause(pause),
        .loop_en(loop_en), .tick(tick), .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_data(rd_data), .note_valid(note_valid), .note_ready(note_ready),
        .note_data(note_data), .gate(gate), .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous note RAM: data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    function automatic logic [31:0] word(input logic [1:0] op, input logic [5:0] dur,
                                         input logic [23:0] pitch);
        return {op, dur, pitch};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic to_idle();
        play = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    task automatic start_play();
        play = 1'b1;
        step();
        play = 1'b0;
    endtask

    task automatic fill_end();
        for (int i = 0; i < 64; i++) mem[i] = word(2'b10, 6'd0, 24'd0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        play   = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({rd_addr, rd_en, note_valid, note_data, gate, playing, done} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%0d en=%b v=%b data=%h gate=%b play=%b done=%b want all zero",
                     rd_addr, rd_en, note_valid, note_data, gate, playing, done);
        end
        play   = 1'b0;
        resetn = 1'b1;
        step();
        step();
        n_cmp++;
        if (playing !== 1'b0 || rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got playing=%b rd_en=%b want 0 0", playing, rd_en);
        end
    endtask

    task automatic test_single_note();
        int lat, beats, k;
        fill_end();
        mem[0] = word(2'b00, 6'd2, 24'h00ABCD);
        loop_en = 1'b0;
        note_ready = 1'b1;
        start_play();
        n_cmp++;
        if (rd_en !== 1'b1 || rd_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL fetch_strobe: got rd_en=%b addr=%0d want 1 0", rd_en, rd_addr);
        end
        lat = 0;
        while (note_valid !== 1'b1 && lat < 10) begin step(); lat++; end
        n_cmp++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL offer_latency: got %0d want 2", lat);
        end
        n_cmp++;
        if (note_data !== 24'h00ABCD) begin
            n_fail++;
            $display("FAIL offer_pitch: got %h want 00abcd", note_data);
        end
        step();
        n_cmp++;
        if (gate !== 1'b1 || note_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_on: got gate=%b valid=%b want 1 0", gate, note_valid);
        end
        beats = 0;
        while (gate === 1'b1 && beats < 10) begin step(); pulse_tick(); beats++; end
        n_cmp++;
        if (beats !== 2) begin
            n_fail++;
            $display("FAIL gate_beats: got %0d want 2", beats);
        end
        k = 0;
        while (done !== 1'b1 && k < 10) begin step(); k++; end
        n_cmp++;
        if (k !== 2) begin
            n_fail++;
            $display("FAIL done_gap: got %0d want 2", k);
        end
        n_cmp++;
        if (done !== 1'b1 || rd_addr !== 6'd1 || playing !== 1'b0 || note_data !== 24'h00ABCD) begin
            n_fail++;
            $display("FAIL done_state: got done=%b addr=%0d playing=%b data=%h want 1 1 0 00abcd",
                     done, rd_addr, playing, note_data);
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || rd_addr !== 6'd1) begin
            n_fail++;
            $display("FAIL done_one_cycle: got done=%b addr=%0d want 0 1", done, rd_addr);
        end
    endtask

    task automatic test_loop();
        int  issues;
        bit  saw_done;
        to_idle();
        loop_en = 1'b1;
        note_ready = 1'b1;
        issues = 0;
        saw_done = 1'b0;
        start_play();
        for (int c = 0; c < 300 && issues < 3; c++) begin
            if (note_valid === 1'b1) begin
                issues++;
                n_cmp++;
                if (note_data !== 24'h00ABCD || rd_addr !== 6'd0) begin
                    n_fail++;
                    $display("FAIL loop_reissue_pitch: got data=%h addr=%0d want 00abcd 0", note_data, rd_addr);
                end
            end
            if (done === 1'b1) saw_done = 1'b1;
            tick = (c % 3 == 0);
            step();
        end
        tick = 1'b0;
        n_cmp++;
        if (issues !== 3) begin
            n_fail++;
            $display("FAIL loop_reissue_count: got %0d want 3", issues);
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_no_done: got done pulse want none");
        end
        to_idle();
        loop_en = 1'b0;
    endtask

    task automatic test_ready_stall();
        int k, beats;
        logic [23:0] held;
        to_idle();
        note_ready = 1'b0;
        start_play();
        k = 0;
        while (note_valid !== 1'b1 && k < 10) begin step(); k++; end
        held = note_data;
        n_cmp++;
        if (held !== 24'h00ABCD) begin
            n_fail++;
            $display("FAIL stall_pitch: got %h want 00abcd", held);
        end
        tick = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_cmp++;
            if (note_valid !== 1'b1 || note_data !== held || gate !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d got valid=%b data=%h gate=%b want 1 %h 0",
                         c, note_valid, note_data, gate, held);
            end
        end
        tick = 1'b0;
        note_ready = 1'b1;
        step();
        n_cmp++;
        if (gate !== 1'b1 || note_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_accept: got gate=%b valid=%b want 1 0", gate, note_valid);
        end
        beats = 0;
        while (gate === 1'b1 && beats < 10) begin step(); pulse_tick(); beats++; end
        n_cmp++;
        if (beats !== 2) begin
            n_fail++;
            $display("FAIL stall_beats: got %0d want 2", beats);
        end
        k = 0;
        while (done !== 1'b1 && k < 10) begin step(); k++; end
        to_idle();
    endtask

    task automatic test_rest_walk();
        bit early_done;
        for (int i = 0; i < 64; i++)
            mem[i] = word((i % 2 == 1) ? 2'b11 : 2'b01, 6'd0, 24'($urandom));
        to_idle();
        loop_en = 1'b0;
        early_done = 1'b0;
        start_play();
        for (int i = 0; i < 64; i++) begin
            repeat (4) begin
                step();
                if (done === 1'b1) early_done = 1'b1;
            end
            n_cmp++;
            if (rd_addr !== i[5:0] || playing !== 1'b1 || gate !== 1'b0) begin
                n_fail++;
                $display("FAIL rest_addr: got addr=%0d playing=%b gate=%b want %0d 1 0", rd_addr, playing, gate, i);
            end
            pulse_tick();
            n_cmp++;
            if (done !== (i == 63)) begin
                n_fail++;
                $display("FAIL rest_done_timing: entry %0d got done=%b want %b", i, done, (i == 63));
            end
        end
        n_cmp++;
        if (early_done !== 1'b0 || rd_addr !== 6'd63 || playing !== 1'b0) begin
            n_fail++;
            $display("FAIL rest_end: got early=%b addr=%0d playing=%b want 0 63 0", early_done, rd_addr, playing);
        end
        repeat (3) begin step(); pulse_tick(); end
        n_cmp++;
        if (rd_addr !== 6'd63 || playing !== 1'b0 || rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rest_no_wrap: got addr=%0d playing=%b rd_en=%b want 63 0 0", rd_addr, playing, rd_en);
        end
    endtask

    task automatic test_pause();
        int k, beats;
        fill_end();
        mem[0] = word(2'b00, 6'd3, 24'($urandom));
        to_idle();
        note_ready = 1'b1;
        start_play();
        k = 0;
        while (gate !== 1'b1 && k < 10) begin step(); k++; end
        step();
        pulse_tick();
        n_cmp++;
        if (gate !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_first_beat: got gate=%b want 1", gate);
        end
        pause = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step();
            pulse_tick();
            n_cmp++;
            if (gate !== 1'b1 || playing !== 1'b1) begin
                n_fail++;
                $display("FAIL pause_frozen: tick %0d got gate=%b playing=%b want 1 1", t, gate, playing);
            end
        end
        pause = 1'b0;
        beats = 0;
        while (gate === 1'b1 && beats < 10) begin step(); pulse_tick(); beats++; end
        n_cmp++;
        if (beats !== 2) begin
            n_fail++;
            $display("FAIL pause_resume_beats: got %0d want 2", beats);
        end
        k = 0;
        while (done !== 1'b1 && k < 10) begin step(); k++; end
        to_idle();
    endtask

    task automatic test_stop();
        int k;
        bit bad;
        fill_end();
        mem[0] = word(2'b01, 6'd1, 24'd0);
        mem[1] = word(2'b00, 6'd5, 24'h123456);
        to_idle();
        note_ready = 1'b0;
        start_play();
        repeat (3) step();
        pulse_tick();
        k = 0;
        while (note_valid !== 1'b1 && k < 10) begin step(); k++; end
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_cmp++;
        if ({note_valid, gate, playing, done, rd_en, rd_addr} !== 11'd0) begin
            n_fail++;
            $display("FAIL stop_issue: got v=%b gate=%b playing=%b done=%b en=%b addr=%0d want all zero",
                     note_valid, gate, playing, done, rd_en, rd_addr);
        end
        bad = 1'b0;
        repeat (3) begin step(); if (done !== 1'b0 || playing !== 1'b0) bad = 1'b1; end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_issue_stays_idle: got activity want idle");
        end
        note_ready = 1'b1;
        start_play();
        repeat (3) step();
        pulse_tick();
        k = 0;
        while (gate !== 1'b1 && k < 10) begin step(); k++; end
        n_cmp++;
        if (rd_addr !== 6'd1 || gate !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_hold_pre: got addr=%0d gate=%b want 1 1", rd_addr, gate);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_cmp++;
        if ({note_valid, gate, playing, done, rd_en, rd_addr} !== 11'd0) begin
            n_fail++;
            $display("FAIL stop_hold: got v=%b gate=%b playing=%b done=%b en=%b addr=%0d want all zero",
                     note_valid, gate, playing, done, rd_en, rd_addr);
        end
        stop = 1'b1;
        play = 1'b1;
        step();
        stop = 1'b0;
        play = 1'b0;
        n_cmp++;
        if (playing !== 1'b0 || rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_beats_play: got playing=%b rd_en=%b want 0 0", playing, rd_en);
        end
        start_play();
        repeat (3) step();
        pulse_tick();
        k = 0;
        while (gate !== 1'b1 && k < 10) begin step(); k++; end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({note_valid, gate, playing, done, rd_en, rd_addr} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got v=%b gate=%b playing=%b done=%b en=%b addr=%0d want all zero",
                     note_valid, gate, playing, done, rd_en, rd_addr);
        end
        step();
        resetn = 1'b1;
        step();
        n_cmp++;
        if (playing !== 1'b0 || done !== 1'b0 || note_data !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_release: got playing=%b done=%b data=%h want 0 0 0", playing, done, note_data);
        end
    endtask

    task automatic test_random();
        logic [23:0] exp_pitch[$];
        int          exp_dur[$];
        int          end_addr, cur_dur, seg, r, d;
        bit          finished;
        logic        prev_valid, prev_ready, prev_gate, prev_tick, prev_pause;
        logic [23:0] prev_data;
        for (int run = 0; run < 4; run++) begin
            for (int i = 0; i < 64; i++) begin
                r = $urandom_range(0, 24);
                mem[i] = word((r == 0) ? 2'b10 : (r <= 13) ? 2'b00 : (r <= 22) ? 2'b01 : 2'b11,
                              6'($urandom_range(0, 3)), 24'($urandom));
            end
            exp_pitch.delete();
            exp_dur.delete();
            end_addr = 0;
            for (int a = 0; a < 64; a++) begin
                end_addr = a;
                if (mem[a][31:30] == 2'b10) break;
                if (mem[a][31:30] == 2'b00) begin
                    d = int'(mem[a][29:24]);
                    exp_pitch.push_back(mem[a][23:0]);
                    exp_dur.push_back((d == 0) ? 1 : d);
                end
            end
            to_idle();
            loop_en = 1'b0; pause = 1'b0; tick = 1'b0; note_ready = 1'b0;
            start_play();
            prev_valid = 1'b0; prev_ready = 1'b0; prev_gate = 1'b0;
            prev_tick = 1'b0; prev_pause = 1'b0; prev_data = 24'd0;
            finished = 1'b0; cur_dur = 0; seg = 0;
            for (int c = 0; c < 6000 && !finished; c++) begin
                if (prev_valid && prev_ready) begin
                    n_cmp++;
                    if (exp_pitch.size() == 0 || prev_data !== exp_pitch[0]) begin
                        n_fail++;
                        $display("FAIL rand_pitch: run %0d got %h want %h (left %0d)", run, prev_data,
                                 (exp_pitch.size() > 0) ? exp_pitch[0] : 24'd0, exp_pitch.size());
                    end
                    if (exp_pitch.size() > 0) begin
                        void'(exp_pitch.pop_front());
                        cur_dur = exp_dur.pop_front();
                    end
                end
                if (prev_gate && prev_tick && !prev_pause) seg++;
                if (!prev_gate && gate) seg = 0;
                if (prev_gate && !gate) begin
                    n_cmp++;
                    if (seg !== cur_dur) begin
                        n_fail++;
                        $display("FAIL rand_gate_beats: run %0d got %0d want %0d", run, seg, cur_dur);
                    end
                end
                if (prev_valid && !prev_ready && note_valid) begin
                    n_cmp++;
                    if (note_data !== prev_data) begin
                        n_fail++;
                        $display("FAIL rand_stable: run %0d got %h want %h", run, note_data, prev_data);
                    end
                end
                if (done === 1'b1) begin
                    finished = 1'b1;
                    n_cmp++;
                    if (rd_addr !== end_addr[5:0] || exp_pitch.size() != 0) begin
                        n_fail++;
                        $display("FAIL rand_end: run %0d got addr=%0d left=%0d want %0d 0",
                                 run, rd_addr, exp_pitch.size(), end_addr);
                    end
                end
                prev_valid = note_valid;
                prev_data  = note_data;
                prev_gate  = gate;
                note_ready = ($urandom_range(0, 2) != 0);
                tick       = ($urandom_range(0, 2) == 0);
                pause      = ($urandom_range(0, 4) == 0);
                prev_ready = note_ready;
                prev_tick  = tick;
                prev_pause = pause;
                step();
            end
            tick = 1'b0;
            pause = 1'b0;
            n_cmp++;
            if (!finished) begin
                n_fail++;
                $display("FAIL rand_timeout: run %0d got no done want done", run);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        test_reset();
        test_single_note();
        test_loop();
        test_ready_stall();
        test_rest_walk();
        test_pause();
        test_stop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
